pi_delta_u: RTL and testbench

Velocity-form PI increment stage of the PI controller. Accepts a setpoint/measurement pair, computes error e[k] and Δe = e[k] − e[k−1], and produces delta_u = (KP·Δe + KI·e[k]) >> FRAC_BITS, saturated to DATA_WIDTH. Sits directly upstream of the control-output/integrator-clip stage. It drives that stage's `delta_u` and 4-bit `state` inputs; the stage latches u on state code 3 (computeU).

---
 rtl/pi_pkg.sv | 33 +++
 rtl/pi_saturate.sv | 24 ++
 rtl/pi_delta_u.sv | 136 +++++++++++++
 tb/tb_pi_delta_u.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pi_pkg.sv
// Shared definitions for the PI controller datapath: default widths,
// FSM state codes (also decoded by the control-output stage) and a
// generic signed saturation helper.
package pi_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_COEF_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 8;

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] CALC_ERR  = 4'd1;
    localparam logic [3:0] MULTIPLY  = 4'd2;
    localparam logic [3:0] COMPUTE_U = 4'd3;
    localparam logic [3:0] UPDATE    = 4'd4;

    // Clip a sign-extended value into the signed range of out_width bits.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] x,
        input int unsigned        out_width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_width - 1));
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/pi_saturate.sv
// Combinational signed clip from IN_WIDTH to OUT_WIDTH bits.
module pi_saturate
    import pi_pkg::*;
#(
    parameter int IN_WIDTH  = 17,
    parameter int OUT_WIDTH = 16
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout
);

    logic signed [63:0] din_ext;
    logic signed [63:0] clipped;
    logic               unused_clip_hi;

    // Sign-extend, clip, then keep only the in-range low bits.
    always_comb begin
        din_ext        = {{(64 - IN_WIDTH){din[IN_WIDTH-1]}}, din};
        clipped        = sat_signed(din_ext, OUT_WIDTH);
        dout           = clipped[OUT_WIDTH-1:0];
        unused_clip_hi = ^clipped[63:OUT_WIDTH];
    end

endmodule

// File: rtl/pi_delta_u.sv
// Velocity-form PI increment stage:
//   delta_u = sat((kp*(e - e_prev) + ki*e) >> FRAC_BITS)
// Five-state sequencer, one sample per five cycles.
// Optional build macro PI_DELTA_ROUND_EN: round half up before the shift
// instead of flooring.
module pi_delta_u
    import pi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] setpoint,
    input  logic signed [DATA_WIDTH-1:0] measurement,
    input  logic signed [COEF_WIDTH-1:0] kp,
    input  logic signed [COEF_WIDTH-1:0] ki,
    output logic signed [DATA_WIDTH-1:0] delta_u,
    output logic [3:0]                   state,
    output logic                         done
);

    localparam int PW = DATA_WIDTH + COEF_WIDTH;
    localparam int SW = PW + 1;

    logic signed [DATA_WIDTH-1:0] sp_q;
    logic signed [DATA_WIDTH-1:0] meas_q;
    logic signed [COEF_WIDTH-1:0] kp_q;
    logic signed [COEF_WIDTH-1:0] ki_q;
    logic signed [DATA_WIDTH-1:0] e_q;
    logic signed [DATA_WIDTH-1:0] de_q;
    logic signed [DATA_WIDTH-1:0] e_prev_q;

    logic signed [DATA_WIDTH:0]   err_wide;
    logic signed [DATA_WIDTH-1:0] e_sat;
    logic signed [DATA_WIDTH:0]   de_wide;
    logic signed [DATA_WIDTH-1:0] de_sat;
    logic signed [PW-1:0]         kp_ext, ki_ext, de_ext, e_ext;
    logic signed [PW-1:0]         prod_p, prod_i;
    logic signed [SW-1:0]         sum, sum_adj, shifted;
    logic signed [DATA_WIDTH-1:0] du_sat;

    // Error and error difference, both one bit wider than the data path.
    always_comb begin
        err_wide = {sp_q[DATA_WIDTH-1], sp_q} - {meas_q[DATA_WIDTH-1], meas_q};
        de_wide  = {e_sat[DATA_WIDTH-1], e_sat} - {e_prev_q[DATA_WIDTH-1], e_prev_q};
    end

    pi_saturate #(.IN_WIDTH(DATA_WIDTH + 1), .OUT_WIDTH(DATA_WIDTH)) u_sat_e (
        .din  (err_wide),
        .dout (e_sat)
    );

    pi_saturate #(.IN_WIDTH(DATA_WIDTH + 1), .OUT_WIDTH(DATA_WIDTH)) u_sat_de (
        .din  (de_wide),
        .dout (de_sat)
    );

    // Two dedicated multipliers, sum with one guard bit, optional rounding, shift.
    always_comb begin
        kp_ext = {{DATA_WIDTH{kp_q[COEF_WIDTH-1]}}, kp_q};
        ki_ext = {{DATA_WIDTH{ki_q[COEF_WIDTH-1]}}, ki_q};
        de_ext = {{COEF_WIDTH{de_q[DATA_WIDTH-1]}}, de_q};
        e_ext  = {{COEF_WIDTH{e_q[DATA_WIDTH-1]}}, e_q};
        prod_p = kp_ext * de_ext;
        prod_i = ki_ext * e_ext;
        sum    = {prod_p[PW-1], prod_p} + {prod_i[PW-1], prod_i};
`ifdef PI_DELTA_ROUND_EN
        sum_adj = sum + SW'(64'd1 << (FRAC_BITS - 1));
`else
        sum_adj = sum;
`endif
        shifted = sum_adj >>> FRAC_BITS;
    end

    pi_saturate #(.IN_WIDTH(SW), .OUT_WIDTH(DATA_WIDTH)) u_sat_u (
        .din  (shifted),
        .dout (du_sat)
    );

    // Sequencer and datapath registers; reset aborts any computation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sp_q     <= '0;
            meas_q   <= '0;
            kp_q     <= '0;
            ki_q     <= '0;
            e_q      <= '0;
            de_q     <= '0;
            e_prev_q <= '0;
            delta_u  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sp_q   <= setpoint;
                        meas_q <= measurement;
                        kp_q   <= kp;
                        ki_q   <= ki;
                        state  <= CALC_ERR;
                    end
                end
                CALC_ERR: begin
                    e_q   <= e_sat;
                    de_q  <= de_sat;
                    state <= MULTIPLY;
                end
                MULTIPLY: begin
                    delta_u <= du_sat;
                    state   <= COMPUTE_U;
                end
                COMPUTE_U: begin
                    state <= UPDATE;
                end
                UPDATE: begin
                    e_prev_q <= e_q;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake and completion flags decoded from the registered state.
    always_comb begin
        in_ready = (state == IDLE);
        done     = (state == UPDATE);
    end

endmodule

// File: tb/tb_pi_delta_u.sv
// Directed self-checking bench for pi_delta_u (16/16/8 configuration).
module tb_pi_delta_u;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic signed [15:0] setpoint;
    logic signed [15:0] measurement;
    logic signed [15:0] kp;
    logic signed [15:0] ki;
    logic signed [15:0] delta_u;
    logic [3:0]        state;
    logic              done;

    int checks = 0;
    int errors = 0;

`ifdef PI_DELTA_ROUND_EN
    localparam logic signed [15:0] RND_EXP = -16'sd1;
`else
    localparam logic signed [15:0] RND_EXP = -16'sd2;
`endif

    always #5 clk = ~clk;

    pi_delta_u #(.DATA_WIDTH(16), .COEF_WIDTH(16), .FRAC_BITS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .setpoint    (setpoint),
        .measurement (measurement),
        .kp          (kp),
        .ki          (ki),
        .delta_u     (delta_u),
        .state       (state),
        .done        (done)
    );

    // Offer one sample from IDLE, then observe 8 cycles (k=1 is right after the accept edge).
    task automatic run_sample(input logic signed [15:0] sp, input logic signed [15:0] meas,
                              input logic signed [15:0] kpv, input logic signed [15:0] kiv,
                              output logic signed [15:0] du, output int lat3,
                              output int latdone, output int latidle, output int n3);
        setpoint = sp; measurement = meas; kp = kpv; ki = kiv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        du = '0; lat3 = -1; latdone = -1; latidle = -1; n3 = 0;
        for (int k = 1; k <= 8; k++) begin
            if (state == 4'd3) begin
                n3++;
                if (lat3 < 0) begin lat3 = k; du = delta_u; end
            end
            if (done && latdone < 0) latdone = k;
            if (in_ready && latidle < 0) latidle = k;
            if (k < 8) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0;
        setpoint = '0; measurement = '0; kp = '0; ki = '0;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (delta_u !== 16'sd0) begin errors++; $display("FAIL reset_delta_u: got %0d want 0", delta_u); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        logic signed [15:0] du;
        int l3, ld, li, n3;
        run_sample(16'sd100, 16'sd60, 16'sd256, 16'sd128, du, l3, ld, li, n3);
        checks++; if (du !== 16'sd60) begin errors++; $display("FAIL basic_delta_u: got %0d want 60", du); end
        checks++; if (l3 !== 3) begin errors++; $display("FAIL basic_lat_state3: got %0d want 3", l3); end
        checks++; if (ld !== 4) begin errors++; $display("FAIL basic_lat_done: got %0d want 4", ld); end
        checks++; if (li !== 5) begin errors++; $display("FAIL basic_lat_ready: got %0d want 5", li); end
        checks++; if (n3 !== 1) begin errors++; $display("FAIL basic_state3_cycles: got %0d want 1", n3); end
    endtask

    task automatic test_second_sample;
        logic signed [15:0] du;
        int l3, ld, li, n3;
        run_sample(16'sd100, 16'sd60, 16'sd256, 16'sd128, du, l3, ld, li, n3);
        checks++; if (du !== 16'sd20) begin errors++; $display("FAIL second_delta_u: got %0d want 20", du); end
    endtask

    task automatic test_err_saturation;
        logic signed [15:0] du;
        int l3, ld, li, n3;
        run_sample(16'sd32767, 16'sh8000, 16'sd32767, 16'sd32767, du, l3, ld, li, n3);
        checks++; if (du !== 16'sd32767) begin errors++; $display("FAIL sat_pos_delta_u: got %0d want 32767", du); end
        run_sample(16'sh8000, 16'sd32767, 16'sd32767, 16'sd32767, du, l3, ld, li, n3);
        checks++; if (du !== 16'sh8000) begin errors++; $display("FAIL sat_neg_delta_u: got %0d want -32768", du); end
    endtask

    task automatic test_rounding;
        logic signed [15:0] du;
        int l3, ld, li, n3;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        run_sample(16'sd0, 16'sd3, 16'sd0, 16'sd128, du, l3, ld, li, n3);
        checks++; if (du !== RND_EXP) begin errors++; $display("FAIL round_delta_u: got %0d want %0d", du, RND_EXP); end
    endtask

    // e_prev = -3 here; sample (100,60) gives e=40, de=43 -> (11008+5120)>>8 = 63.
    task automatic test_busy;
        setpoint = 16'sd100; measurement = 16'sd60; kp = 16'sd256; ki = 16'sd128; in_valid = 1'b1;
        @(posedge clk); #1;
        setpoint = 16'sd1000; measurement = -16'sd1000; kp = 16'sd1; ki = 16'sd1;
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL busy_state_calc: got %0d want 1", state); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_ready_calc: got %b want 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL busy_ready_mult: got %b want 0", in_ready); end
        checks++; if (delta_u !== RND_EXP) begin errors++; $display("FAIL busy_du_held: got %0d want %0d", delta_u, RND_EXP); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (state !== 4'd3) begin errors++; $display("FAIL busy_state3: got %0d want 3", state); end
        checks++; if (delta_u !== 16'sd63) begin errors++; $display("FAIL busy_delta_u: got %0d want 63", delta_u); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL busy_no_queue: got state %0d want 0", state); end
    endtask

    task automatic test_reset_mid;
        int n3;
        setpoint = 16'sd200; measurement = 16'sd60; kp = 16'sd256; ki = 16'sd128; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (state !== 4'd2) begin errors++; $display("FAIL rstmid_in_multiply: got %0d want 2", state); end
        #1 reset = 1'b1;
        #1;
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL rstmid_state: got %0d want 0", state); end
        checks++; if (delta_u !== 16'sd0) begin errors++; $display("FAIL rstmid_delta_u: got %0d want 0", delta_u); end
        n3 = 0;
        @(posedge clk); #1;
        if (state == 4'd3) n3++;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (state == 4'd3) n3++;
        end
        checks++; if (n3 !== 0) begin errors++; $display("FAIL rstmid_no_state3: got %0d cycles want 0", n3); end
    endtask

    // Held in_valid: first result uses cleared e_prev (60), second de=0 (20), 5 cycles apart.
    task automatic test_back_to_back;
        logic signed [15:0] du0, du1;
        int found, t0, t1;
        found = 0; t0 = -1; t1 = -1; du0 = '0; du1 = '0;
        setpoint = 16'sd100; measurement = 16'sd60; kp = 16'sd256; ki = 16'sd128; in_valid = 1'b1;
        for (int k = 1; k <= 16 && found < 2; k++) begin
            @(posedge clk); #1;
            if (state == 4'd3) begin
                if (found == 0) begin du0 = delta_u; t0 = k; end
                else begin du1 = delta_u; t1 = k; end
                found++;
            end
        end
        in_valid = 1'b0;
        checks++; if (found !== 2) begin errors++; $display("FAIL b2b_results: got %0d want 2", found); end
        checks++; if (du0 !== 16'sd60) begin errors++; $display("FAIL b2b_first_du: got %0d want 60", du0); end
        checks++; if (du1 !== 16'sd20) begin errors++; $display("FAIL b2b_second_du: got %0d want 20", du1); end
        checks++; if (t1 - t0 !== 5) begin errors++; $display("FAIL b2b_spacing: got %0d want 5", t1 - t0); end
        for (int k = 0; k < 6; k++) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_second_sample();
        test_err_saturation();
        test_rounding();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
